// File: rtl/fnd_scan4.sv
// fnd_scan4 - four-digit multiplexed 7-segment (FND) display driver.
//
// Time-multiplexes a packed four-digit BCD word onto a common-anode display
// and stretches receive-error events into a blinking LED. It also lights the
// decimal point of digit 0 while the error LED sequence is running.
// A new word is taken only at frame boundaries, so a frame never mixes the
// digits of two different words. All outputs come straight from flops.
//
// Ports:
//   i_clk       system clock
//   i_rstn      asynchronous active-low reset
//   i_bcd8d     packed BCD word, [15:12] = digit 3 (leftmost), [3:0] = digit 0
//   i_rx_err    receive error; every cycle it is high starts or restarts a blink
//   i_blank_lz  leading-zero blanking enable, taken at frame boundaries
//   o_fnd_com   digit commons, active-low, bit n = digit n
//   o_fnd_seg   segments, active-low, {dp,g,f,e,d,c,b,a}
//   o_err_led   error indicator, active-high
module fnd_scan4 #(
  parameter int SCAN_DIV      = 20000,
  parameter int GUARD         = 16,
  parameter int BLINK_SLOTS   = 250,
  parameter int BLINK_TOGGLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bcd8d,
  input  logic        i_rx_err,
  input  logic        i_blank_lz,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_seg,
  output logic        o_err_led
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(BLINK_SLOTS + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(BLINK_SLOTS - 1);
  localparam logic [TW-1:0] TOG_LAST  = TW'(BLINK_TOGGLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BLINK = 1'b1
  } err_state_t;

  // Scan timing state
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic          armed_q;
  logic          armed_d;
  logic          tick;
  logic          frame_bnd;

  // Shadowed display data
  logic [15:0]   shadow_word_q;
  logic          shadow_blz_q;

  // Output registers
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    com_q;

  // Decode path
  logic [15:0]   eff_word;
  logic          eff_blz;
  logic [3:0]    zero;
  logic [3:0]    lead;
  logic [3:0]    nib;
  logic [6:0]    seg_nxt;

  // Error sequencer
  err_state_t    state_q;
  err_state_t    state_d;
  logic          led_q;
  logic          led_d;
  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;
  logic [TW-1:0] tog_q;
  logic [TW-1:0] tog_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_bnd = tick && (idx_q == 2'd3);
  assign idx_d     = tick ? idx_q + 2'd1 : idx_q;
  // The slot before the first tick after reset has no valid digit assigned,
  // so nothing is driven until the scan has actually advanced once.
  assign armed_d   = armed_q | tick;

  // Pattern for the slot that begins after this tick. On the frame boundary
  // the shadow is being loaded in the same cycle, so the incoming word is
  // used directly; digit 0 of the new frame then already shows it.
  always_comb begin
    eff_word = frame_bnd ? i_bcd8d : shadow_word_q;
    eff_blz  = frame_bnd ? i_blank_lz : shadow_blz_q;
    for (int n = 0; n < 4; n++) begin
      zero[n] = (eff_word[n*4 +: 4] == 4'h0);
    end
    // lead[n]: digit n and every digit above it are zero. Digit 0 is kept so
    // an all-zero word still shows a single "0".
    lead[3] = zero[3];
    lead[2] = zero[3] & zero[2];
    lead[1] = zero[3] & zero[2] & zero[1];
    lead[0] = 1'b0;
    nib     = eff_word[{idx_d, 2'b00} +: 4];
    seg_nxt = (eff_blz && lead[idx_d]) ? 7'h7F : seg_decode(nib);
  end

  // Prescaler, digit index, shadow capture and the com/seg output registers.
  // Commons are released on the tick and the newly selected one is pulled low
  // GUARD cycles later, giving the segments time to settle (anti-ghosting).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      armed_q       <= 1'b0;
      shadow_word_q <= 16'h0000;
      shadow_blz_q  <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      com_q         <= 4'hF;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + 1'b1;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      if (frame_bnd) begin
        shadow_word_q <= i_bcd8d;
        shadow_blz_q  <= i_blank_lz;
      end
      if (tick) begin
        seg_q <= seg_nxt;
      end
      if (tick) begin
        com_q <= 4'hF;
      end else if (armed_q && (cnt_q == CNT_GUARD)) begin
        com_q <= ~(4'b0001 << idx_q);
      end
      dp_q <= ~((state_d == S_BLINK) && armed_d && (idx_d == 2'd0));
    end
  end

  // Error sequencer state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      led_q   <= 1'b0;
      slot_q  <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      slot_q  <= slot_d;
      tog_q   <= tog_d;
    end
  end

  // Error sequencer next state. A new error always wins, including on the
  // tick of the final toggle, so the LED never drops between back-to-back
  // events.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    slot_d  = slot_q;
    tog_d   = tog_q;
    if (i_rx_err) begin
      state_d = S_BLINK;
      led_d   = 1'b1;
      slot_d  = '0;
      tog_d   = '0;
    end else if ((state_q == S_BLINK) && tick) begin
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        if (tog_q == TOG_LAST) begin
          state_d = S_IDLE;
          led_d   = 1'b0;
          tog_d   = '0;
        end else begin
          tog_d = tog_q + 1'b1;
          led_d = ~led_q;
        end
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  assign o_fnd_com = com_q;
  assign o_fnd_seg = {dp_q, seg_q};
  assign o_err_led = led_q;

endmodule

// File: tb/tb_fnd_scan4.sv
// tb_fnd_scan4 - self-checking bench for fnd_scan4.
//
// A reference model counts cycles since reset and derives slot, digit, frame
// capture and error-LED phase arithmetically. At each slot tick it queues the
// pattern the coming slot should show; a monitor pops an entry whenever a
// common goes low and also checks com, LED and dp on every cycle.
module tb_fnd_scan4;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BS = 2;
  localparam int BT = 4;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic [15:0] i_bcd8d = 16'h0000;
  logic        i_rx_err = 1'b0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_seg;
  logic        o_err_led;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          k = 0;
  int          last_err = 0;
  bit          err_seen = 1'b0;
  logic [15:0] cap_word = 16'h0000;
  logic        cap_blz = 1'b0;
  logic [10:0] exp_q[$];
  logic [3:0]  prev_com = 4'hF;
  logic [7:0]  dec_tbl [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_scan4 #(
    .SCAN_DIV(SD),
    .GUARD(GD),
    .BLINK_SLOTS(BS),
    .BLINK_TOGGLES(BT)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_bcd8d(i_bcd8d),
    .i_rx_err(i_rx_err),
    .i_blank_lz(i_blank_lz),
    .o_fnd_com(o_fnd_com),
    .o_fnd_seg(o_fnd_seg),
    .o_err_led(o_err_led)
  );

  always #5 i_clk = ~i_clk;

  // Expected 7-bit pattern of digit n of word w
  function automatic logic [6:0] ref_digit(input logic [15:0] w, input logic blz, input int n);
    logic [3:0] nib;
    logic [7:0] full;
    bit all_zero;
    nib = w[4*n +: 4];
    all_zero = 1'b1;
    for (int m = n; m < 4; m++) begin
      if (w[4*m +: 4] != 4'h0) all_zero = 1'b0;
    end
    if (blz && n != 0 && all_zero) full = 8'hFF;
    else if (nib <= 4'd9) full = dec_tbl[nib];
    else full = 8'hBF;
    return full[6:0];
  endfunction

  function automatic logic [3:0] one_cold(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << n);
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t cycle=%0d: got %h expected %h", name, $time, k, got, exp);
    end
  endtask

  // Drive one input setting; an error request is a single-cycle pulse
  task automatic apply_stimulus(input logic [15:0] w, input logic blz, input logic err, input int cycles);
    i_bcd8d    = w;
    i_blank_lz = blz;
    i_rx_err   = err;
    @(negedge i_clk);
    i_rx_err = 1'b0;
    repeat (cycles - 1) @(negedge i_clk);
  endtask

  // Assert reset between clock edges and check outputs before any edge
  task automatic pulse_reset();
    #2 i_rstn = 1'b0;
    #1;
    check_output("rst_com", {28'd0, o_fnd_com}, 32'hF);
    check_output("rst_seg", {24'd0, o_fnd_seg}, 32'hFF);
    check_output("rst_led", {31'd0, o_err_led}, 32'd0);
    repeat (2) @(negedge i_clk);
    #2 i_rstn = 1'b1;
  endtask

  // Reference model: period k is the k-th cycle after reset release
  initial begin
    int slot;
    int idx;
    forever begin
      @(posedge i_clk or negedge i_rstn);
      if (!i_rstn) begin
        k = 0;
        err_seen = 1'b0;
        last_err = 0;
        cap_word = 16'h0000;
        cap_blz = 1'b0;
        exp_q.delete();
      end else begin
        if (i_rx_err) begin
          err_seen = 1'b1;
          last_err = k;
        end
        if (k % SD == SD - 1) begin
          slot = (k + 1) / SD;
          idx = slot % 4;
          if (idx == 0) begin
            cap_word = i_bcd8d;
            cap_blz = i_blank_lz;
          end
          exp_q.push_back({one_cold(idx), ref_digit(cap_word, cap_blz, idx)});
        end
        k = k + 1;
      end
    end
  end

  // Monitor: per-cycle com/LED/dp checks, slot pattern popped on com onset
  initial begin
    int slot;
    int n;
    bit blink;
    logic [3:0] exp_com;
    logic exp_led;
    logic exp_dp;
    logic [10:0] e;
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        slot = k / SD;
        exp_com = (slot >= 1 && (k % SD) >= GD) ? one_cold(slot % 4) : 4'hF;
        n = k / SD - (last_err + 1) / SD;
        blink = err_seen && (n < BT * BS);
        exp_led = blink && (((n / BS) % 2) == 0);
        exp_dp = !(blink && slot >= 1 && (slot % 4) == 0);
        check_output("com", {28'd0, o_fnd_com}, {28'd0, exp_com});
        check_output("com_onehot", {31'd0, ($countones(~o_fnd_com) <= 1)}, 32'd1);
        check_output("err_led", {31'd0, o_err_led}, {31'd0, exp_led});
        check_output("dp", {31'd0, o_fnd_seg[7]}, {31'd0, exp_dp});
        if (o_fnd_com != 4'hF && prev_com == 4'hF) begin
          if (exp_q.size() == 0) begin
            check_output("slot_queue_empty", {28'd0, o_fnd_com}, 32'hF);
          end else begin
            e = exp_q.pop_front();
            check_output("slot_com", {28'd0, o_fnd_com}, {28'd0, e[10:7]});
            check_output("slot_seg", {25'd0, o_fnd_seg[6:0]}, {25'd0, e[6:0]});
          end
        end
        prev_com = o_fnd_com;
      end else begin
        prev_com = 4'hF;
      end
    end
  end

  initial begin
    logic [15:0] w;
    $display("[TB] fnd_scan4 bench start");
    pulse_reset();

    // Plain scan, then leading-zero blanking cases
    apply_stimulus(16'h1234, 1'b0, 1'b0, 3 * 4 * SD);
    apply_stimulus(16'h0070, 1'b1, 1'b0, 2 * 4 * SD);
    apply_stimulus(16'h0000, 1'b1, 1'b0, 2 * 4 * SD);
    apply_stimulus(16'h9A0F, 1'b1, 1'b0, 2 * 4 * SD);

    // Mid-frame change must wait for the next frame boundary
    apply_stimulus(16'h1111, 1'b0, 1'b0, 4 * SD + 13);
    apply_stimulus(16'h2222, 1'b0, 1'b0, 2 * 4 * SD);

    // Single error event runs to completion
    apply_stimulus(16'h5678, 1'b0, 1'b1, 10 * SD);

    // Restart during blink, then reset in the middle of a slot
    apply_stimulus(16'h5678, 1'b0, 1'b1, 3 * SD);
    apply_stimulus(16'h5678, 1'b0, 1'b1, 5);
    pulse_reset();
    apply_stimulus(16'h4321, 1'b1, 1'b0, 2 * 4 * SD);

    // Randomized traffic, including invalid nibbles and sparse errors
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = 16'($urandom);
      end else begin
        w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 2) == 0) w[15:8] = 8'h00;
      end
      apply_stimulus(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                     $urandom_range(1, 24));
    end
    apply_stimulus(16'h0000, 1'b0, 1'b0, 12 * SD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
